// File: rtl/uart_tx_if.sv
// Handshake and format bundle between Tx_FSM (master) and the transmit datapath (slave).
interface uart_tx_if;
  logic       tx_tick;
  logic       shift_load;
  logic       syn_clr;
  logic [1:0] tx_control;
  logic [7:0] tx_data;
  logic [1:0] WLS;
  logic       EPS;
  logic       SP;
  logic       BC;
  logic       txd;
  logic       data_done;
  logic       tx_fifo_rd;
  logic       tx_busy;

  modport master (
    output tx_tick, shift_load, syn_clr, tx_control, tx_data, WLS, EPS, SP, BC,
    input  txd, data_done, tx_fifo_rd, tx_busy
  );

  modport slave (
    input  tx_tick, shift_load, syn_clr, tx_control, tx_data, WLS, EPS, SP, BC,
    output txd, data_done, tx_fifo_rd, tx_busy
  );
endinterface

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: captures a character and its frame format on load,
// shifts data bits LSB first on bit ticks and drives a registered txd line.
module uart_tx_datapath (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus
);

  localparam logic [1:0] CTL_MARK   = 2'b00;
  localparam logic [1:0] CTL_START  = 2'b01;
  localparam logic [1:0] CTL_DATA   = 2'b10;
  localparam logic [1:0] CTL_PARITY = 2'b11;

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] nbits_m1_q, nbits_m1_d;
  logic       par_bit_q, par_bit_d;
  logic       busy_q, busy_d;
  logic       txd_q, txd_d;

  logic [7:0] load_mask;
  logic [7:0] load_data;
  logic [2:0] load_nbits_m1;
  logic       load_par;
  logic       at_last_bit;

  // Decode the word length and parity for the character presented at load time.
  always_comb begin
    load_mask     = 8'hFF;
    load_nbits_m1 = 3'd7;
    case (bus.WLS)
      2'b00: begin load_mask = 8'h1F; load_nbits_m1 = 3'd4; end
      2'b01: begin load_mask = 8'h3F; load_nbits_m1 = 3'd5; end
      2'b10: begin load_mask = 8'h7F; load_nbits_m1 = 3'd6; end
      default: begin load_mask = 8'hFF; load_nbits_m1 = 3'd7; end
    endcase
    load_data = bus.tx_data & load_mask;
    if (bus.SP) begin
      load_par = ~bus.EPS;
    end else if (bus.EPS) begin
      load_par = ^load_data;
    end else begin
      load_par = ~^load_data;
    end
  end

  assign at_last_bit = (bit_cnt_q == nbits_m1_q);

  // Next-state for the shift register, counter and frame format; clear beats load beats shift.
  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_m1_d = nbits_m1_q;
    par_bit_d  = par_bit_q;
    busy_d     = busy_q;
    if (bus.syn_clr) begin
      shreg_d   = 8'd0;
      bit_cnt_d = 3'd0;
      par_bit_d = 1'b0;
      busy_d    = 1'b0;
    end else if (bus.shift_load) begin
      shreg_d    = load_data;
      bit_cnt_d  = 3'd0;
      nbits_m1_d = load_nbits_m1;
      par_bit_d  = load_par;
      busy_d     = 1'b1;
    end else if ((bus.tx_control == CTL_DATA) && bus.tx_tick && !at_last_bit) begin
      shreg_d   = {1'b0, shreg_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  // Select the line level for the next clock; break overrides everything.
  always_comb begin
    txd_d = 1'b1;
    case (bus.tx_control)
      CTL_MARK:   txd_d = 1'b1;
      CTL_START:  txd_d = 1'b0;
      CTL_DATA:   txd_d = shreg_q[0];
      CTL_PARITY: txd_d = par_bit_q;
      default:    txd_d = 1'b1;
    endcase
    if (bus.BC) begin
      txd_d = 1'b0;
    end
  end

  // State registers; reset parks the line at mark and assumes an 8-bit word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      nbits_m1_q <= 3'd7;
      par_bit_q  <= 1'b0;
      busy_q     <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_m1_q <= nbits_m1_d;
      par_bit_q  <= par_bit_d;
      busy_q     <= busy_d;
      txd_q      <= txd_d;
    end
  end

  // data_done is combinational so the FSM can leave DATA on the tick ending the last bit.
  assign bus.data_done  = (bus.tx_control == CTL_DATA) && at_last_bit;
  assign bus.tx_fifo_rd = bus.shift_load & ~bus.syn_clr;
  assign bus.tx_busy    = busy_q;
  assign bus.txd        = txd_q;

endmodule
